// File: rtl/hub75_rx_if.sv
// hub75_rx_if -- HUB75 panel-side bundle.
// Carries the shift clock, latch, output enable, row address (A is the
// LSB) and the six pixel data lines of a HUB75 panel connector.
//   master : panel driver, drives every line
//   slave  : receiver, samples every line
interface hub75_rx_if;
  logic clk_shft;
  logic LAT;
  logic OE;
  logic A;
  logic B;
  logic C;
  logic D;
  logic R0;
  logic G0;
  logic B0;
  logic R1;
  logic G1;
  logic B1;

  modport master (
    output clk_shft, LAT, OE, A, B, C, D, R0, G0, B0, R1, G1, B1
  );

  modport slave (
    input clk_shft, LAT, OE, A, B, C, D, R0, G0, B0, R1, G1, B1
  );
endinterface

// File: rtl/hub75_rx.sv
// hub75_rx -- HUB75 panel receiver with row frame buffer.
// Samples a HUB75 bus through two-flop synchronizers, shifts one row of
// COLS pixels per burst into top/bottom shift registers and, on the latch,
// commits the row into memory when exactly COLS pixels arrived.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   pnl             hub75_rx_if.slave panel bus (asynchronous to clk)
//   rd_row, rd_col  readback address (bottom half at row+ROWS_HALF)
//   rd_rgb          registered {R,G,B} of the addressed pixel
//   row_done        pulse per committed row
//   frame_done      pulse when row 0 follows row ROWS_HALF-1
//   col_err         pulse when a latch arrives with a pixel count != COLS
//   lit             synchronized inverse of OE
//   err_cnt         saturating col_err counter, present only when
//                   HUB75_RX_ERRCNT_EN is defined
module hub75_rx #(
  parameter int COLS      = 64,
  parameter int ROWS_HALF = 16
) (
  input  logic       clk,
  input  logic       rst,
  hub75_rx_if.slave  pnl,
  input  logic [4:0] rd_row,
  input  logic [5:0] rd_col,
  output logic [2:0] rd_rgb,
  output logic       row_done,
  output logic       frame_done,
  output logic       col_err,
  output logic       lit
`ifdef HUB75_RX_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] CNT_FULL = 7'(COLS);
  localparam logic [6:0] CNT_MAX  = 7'(COLS + 1);
  localparam logic [3:0] ROW_LAST = 4'(ROWS_HALF - 1);

  // Bit map of the synchronized bus: [12] clk_shft, [11] LAT, [10] OE,
  // [9:6] {D,C,B,A}, [5:3] {R0,G0,B0}, [2:0] {R1,G1,B1}.
  logic [12:0] raw_s;
  logic [12:0] sync1_r;
  logic [12:0] sync2_r;
  logic        shft_prev_r;
  logic        lat_prev_r;
  logic        shft_edge_s;
  logic        lat_edge_s;
  logic [3:0]  addr_s;
  logic [4:0]  row_lo_s;
  logic [4:0]  row_hi_s;
  logic        row_ok_s;
  logic        rd_ok_s;

  state_t      state_r;
  state_t      state_next_s;
  logic        do_shift_s;
  logic        commit_s;
  logic        commit_ok_s;
  logic [6:0]  cnt_r;
  logic [3:0]  prev_row_r;

  // Shift registers indexed like the data bits of raw_s; column c sits at bit c.
  logic [COLS-1:0] sr_r [6];
  // Row memory per colour plane: [2] red, [1] green, [0] blue.
  logic [COLS-1:0] mem_r [3][2*ROWS_HALF];

  assign raw_s = {pnl.clk_shft, pnl.LAT, pnl.OE, pnl.D, pnl.C, pnl.B, pnl.A,
                  pnl.R0, pnl.G0, pnl.B0, pnl.R1, pnl.G1, pnl.B1};

  assign shft_edge_s = sync2_r[12] & ~shft_prev_r;
  assign lat_edge_s  = sync2_r[11] & ~lat_prev_r;
  assign addr_s      = sync2_r[9:6];
  assign row_lo_s    = {1'b0, addr_s};
  assign row_hi_s    = row_lo_s + 5'(ROWS_HALF);
  assign row_ok_s    = (32'(addr_s) < ROWS_HALF);
  assign commit_ok_s = commit_s && (cnt_r == CNT_FULL);
  assign rd_ok_s     = (32'(rd_row) < 2 * ROWS_HALF) && (32'(rd_col) < COLS);

  // Two-flop synchronizers plus previous-value flops for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r     <= 13'd0;
      sync2_r     <= 13'd0;
      shft_prev_r <= 1'b0;
      lat_prev_r  <= 1'b0;
    end else begin
      sync1_r     <= raw_s;
      sync2_r     <= sync1_r;
      shft_prev_r <= sync2_r[12];
      lat_prev_r  <= sync2_r[11];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state; a shift coincident with LAT is still taken, and a LAT
  // in IDLE goes to COMMIT so it is reported as an error.
  always_comb begin
    state_next_s = state_r;
    do_shift_s   = 1'b0;
    commit_s     = 1'b0;
    case (state_r)
      IDLE: begin
        do_shift_s = shft_edge_s;
        if (lat_edge_s) begin
          state_next_s = COMMIT;
        end else if (shft_edge_s) begin
          state_next_s = SHIFT;
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        do_shift_s = shft_edge_s;
        if (lat_edge_s) begin
          state_next_s = COMMIT;
        end else begin
          state_next_s = SHIFT;
        end
      end
      COMMIT: begin
        commit_s     = 1'b1;
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Pixel counter: cleared on the way back to IDLE, saturates one past COLS.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 7'd0;
    end else if (state_r == COMMIT) begin
      cnt_r <= 7'd0;
    end else if (do_shift_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + 7'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Row shift registers; new bits enter at the top so column 0 ends at bit 0.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 6; k++) begin
      if (do_shift_s) begin
        sr_r[k] <= {sync2_r[k], sr_r[k][COLS-1:1]};
      end
    end
  end

  // Row memory write on a successful commit; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit_ok_s && row_ok_s) begin
      for (int c = 0; c < 3; c++) begin
        mem_r[c][row_lo_s] <= sr_r[c+3];
        mem_r[c][row_hi_s] <= sr_r[c];
      end
    end
  end

  // Registered status pulses, frame tracking, lit and readback port.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_done   <= 1'b0;
      col_err    <= 1'b0;
      frame_done <= 1'b0;
      prev_row_r <= 4'd0;
      lit        <= 1'b0;
      rd_rgb     <= 3'b000;
    end else begin
      row_done   <= commit_ok_s;
      col_err    <= commit_s && !commit_ok_s;
      frame_done <= commit_ok_s && (addr_s == 4'd0) && (prev_row_r == ROW_LAST);
      if (commit_ok_s) begin
        prev_row_r <= addr_s;
      end else begin
        prev_row_r <= prev_row_r;
      end
      lit <= ~sync2_r[10];
      if (rd_ok_s) begin
        rd_rgb <= {mem_r[2][rd_row][rd_col], mem_r[1][rd_row][rd_col],
                   mem_r[0][rd_row][rd_col]};
      end else begin
        rd_rgb <= 3'b000;
      end
    end
  end

`ifdef HUB75_RX_ERRCNT_EN
  // Saturating count of col_err pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (col_err && (err_cnt != 8'd255)) begin
      err_cnt <= err_cnt + 8'd1;
    end else begin
      err_cnt <= err_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_hub75_rx.sv
// tb_hub75_rx -- self-checking bench for hub75_rx.
// Drives HUB75 bursts through the interface and compares pulses, readback
// and (with HUB75_RX_ERRCNT_EN) err_cnt against a row-level reference model.
module tb_hub75_rx;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rd_row;
  logic [5:0] rd_col;
  logic [2:0] rd_rgb;
  logic       row_done;
  logic       frame_done;
  logic       col_err;
  logic       lit;
`ifdef HUB75_RX_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  hub75_rx_if bus ();

  hub75_rx #(.COLS(64), .ROWS_HALF(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .pnl        (bus),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_rgb     (rd_rgb),
    .row_done   (row_done),
    .frame_done (frame_done),
    .col_err    (col_err),
    .lit        (lit)
`ifdef HUB75_RX_ERRCNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Running pulse totals, sampled on the falling edge.
  int n_row = 0;
  int n_err = 0;
  int n_frame = 0;
  always @(negedge clk) begin
    if (row_done)   n_row   <= n_row + 1;
    if (col_err)    n_err   <= n_err + 1;
    if (frame_done) n_frame <= n_frame + 1;
  end

  // Reference model: row memory image, last good row, error count.
  logic [2:0] model_mem [32][64];
  int         prev_row = 0;
  int         errm = 0;
  logic [2:0] top_px [64];
  logic [2:0] bot_px [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill_rand();
    for (int c = 0; c < 64; c++) begin
      top_px[c] = 3'($urandom);
      bot_px[c] = 3'($urandom);
    end
  endtask

  // lat_mode: 0 no latch, 1 latch after the burst, 2 latch with the last shift.
  task automatic burst(input int n, input logic [3:0] addr, input int lat_mode);
    logic [2:0] t;
    logic [2:0] b;
    {bus.D, bus.C, bus.B, bus.A} = addr;
    for (int i = 0; i < n; i++) begin
      if (i < 64) begin
        t = top_px[i];
        b = bot_px[i];
      end else begin
        t = 3'($urandom);
        b = 3'($urandom);
      end
      {bus.R0, bus.G0, bus.B0} = t;
      {bus.R1, bus.G1, bus.B1} = b;
      wait_cyc(2);
      bus.clk_shft = 1'b1;
      if (lat_mode == 2 && i == n - 1) bus.LAT = 1'b1;
      wait_cyc(3);
      bus.clk_shft = 1'b0;
      bus.LAT = 1'b0;
      wait_cyc(2);
    end
    if (lat_mode == 1 || (lat_mode == 2 && n == 0)) begin
      bus.LAT = 1'b1;
      wait_cyc(3);
      bus.LAT = 1'b0;
    end
    if (lat_mode != 0) wait_cyc(6);
  endtask

  // One latched burst plus model update and pulse checks.
  task automatic do_row(input int n, input logic [3:0] addr, input int lat_mode);
    int r0, e0, f0;
    bit ok, fr;
    r0 = n_row; e0 = n_err; f0 = n_frame;
    burst(n, addr, lat_mode);
    ok = (n == 64);
    fr = ok && (addr == 4'd0) && (prev_row == 15);
    if (ok) begin
      for (int c = 0; c < 64; c++) begin
        model_mem[addr][c]      = top_px[c];
        model_mem[addr + 16][c] = bot_px[c];
      end
      prev_row = int'(addr);
    end else if (errm < 255) begin
      errm++;
    end
    check("row_done", 32'(n_row - r0), 32'(ok));
    check("col_err", 32'(n_err - e0), 32'(!ok));
    check("frame_done", 32'(n_frame - f0), 32'(fr));
  endtask

  task automatic check_row(input int r);
    for (int c = 0; c < 64; c++) begin
      rd_row = 5'(r);
      rd_col = 6'(c);
      wait_cyc(1);
      check("rd_rgb", 32'(rd_rgb), 32'(model_mem[r][c]));
    end
  endtask

  initial begin
    int f0;
    {bus.clk_shft, bus.LAT, bus.OE, bus.A, bus.B, bus.C, bus.D} = 7'd0;
    {bus.R0, bus.G0, bus.B0, bus.R1, bus.G1, bus.B1} = 6'd0;
    rd_row = 5'd0;
    rd_col = 6'd0;
    rst = 1'b1;
    wait_cyc(4);
    check("rst_row_done", 32'(row_done), 32'd0);
    check("rst_col_err", 32'(col_err), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_lit", 32'(lit), 32'd0);
    check("rst_rd_rgb", 32'(rd_rgb), 32'd0);
`ifdef HUB75_RX_ERRCNT_EN
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    rst = 1'b0;

    // lit follows the inverse of OE after synchronization.
    wait_cyc(4);
    check("lit_oe0", 32'(lit), 32'd1);
    bus.OE = 1'b1;
    wait_cyc(4);
    check("lit_oe1", 32'(lit), 32'd0);
    bus.OE = 1'b0;

    // Alternating R0 pattern into row 3.
    for (int c = 0; c < 64; c++) begin
      top_px[c] = (c % 2 == 0) ? 3'b100 : 3'b000;
      bot_px[c] = 3'b000;
    end
    do_row(64, 4'd3, 1);
    rd_row = 5'd3; rd_col = 6'd0; wait_cyc(1);
    check("row3_col0", 32'(rd_rgb), 32'd4);
    rd_col = 6'd1; wait_cyc(1);
    check("row3_col1", 32'(rd_rgb), 32'd0);

    // Short burst: error, memory unchanged.
    fill_rand();
    do_row(63, 4'd3, 1);
    check_row(3);
    check_row(19);
`ifdef HUB75_RX_ERRCNT_EN
    check("err_cnt_one", 32'(err_cnt), 32'(errm));
`endif

    // Random good rows.
    for (int k = 0; k < 3; k++) begin
      fill_rand();
      do_row(64, 4'($urandom_range(0, 15)), 1);
    end
    for (int r = 0; r < 32; r += 9) begin
      if (!$isunknown(model_mem[r][0])) check_row(r);
    end

    // Last shift coincident with LAT.
    fill_rand();
    do_row(64, 4'd7, 2);
    check_row(7);
    check_row(23);

    // Overlong burst saturates the counter and is an error.
    fill_rand();
    do_row(70, 4'd9, 1);

    // Full frame 0..15 then row 0 again.
    f0 = n_frame;
    for (int r = 0; r < 16; r++) begin
      fill_rand();
      do_row(64, 4'(r), 1);
    end
    fill_rand();
    do_row(64, 4'd0, 1);
    check("frame_total", 32'(n_frame - f0), 32'd1);
    check_row(0);
    check_row(16);

    // Reset mid-burst discards the partial row.
    fill_rand();
    burst(30, 4'd5, 0);
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    prev_row = 0;
    errm = 0;
    for (int c = 0; c < 64; c++) begin
      top_px[c] = 3'($urandom);
      bot_px[c] = 3'b001;
    end
    do_row(64, 4'd5, 1);
    check_row(21);
    check_row(5);

    // Many short bursts saturate the error counter.
    for (int k = 0; k < 300; k++) begin
      do_row($urandom_range(0, 5), 4'($urandom_range(0, 15)), 1);
    end
`ifdef HUB75_RX_ERRCNT_EN
    check("err_cnt_sat", 32'(err_cnt), 32'(errm));
    check("err_cnt_255", 32'(err_cnt), 32'd255);
`endif
    check_row(21);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hub75_rx.md
HUB75_RX -- requirements
Module: hub75_rx

Interface
REQ-001 Parameter COLS, default 64: pixels shifted per row; a legal row burst has exactly COLS clock pulses.
REQ-002 Parameter ROWS_HALF, default 16: row addresses per panel half, selected by A..D.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 clk_shft  input  1  panel shift clock, asynchronous to clk.
REQ-006 LAT, OE  input  1 each  panel latch and output-enable (OE active-low = row lit).
REQ-007 A, B, C, D  input  1 each  row address; A is the LSB.
REQ-008 R0, G0, B0, R1, G1, B1  input  1 each  top-half and bottom-half pixel data.
REQ-009 rd_row  input  5  readback row, 0..2*ROWS_HALF-1; the bottom half is at row+ROWS_HALF.
REQ-010 rd_col  input  6  readback column, 0..COLS-1.
REQ-011 rd_rgb  output  3  {R,G,B} of the addressed pixel.
REQ-012 row_done  output  1  one-cycle pulse on each committed row.
REQ-013 frame_done  output  1  one-cycle pulse when a commit has row address 0 and the previous commit had row address ROWS_HALF-1.
REQ-014 col_err  output  1  one-cycle pulse when a latch arrives with a pixel count other than COLS.
REQ-015 lit  output  1  synchronized inverse of OE.

Function
REQ-016 clk_shft, LAT, OE, A..D and all six data inputs shall each pass through a two-flop synchronizer; all decisions use the second stage.
REQ-017 A clk_shft rising edge is second stage 1 with the previous second-stage value 0. On that edge, the data present on the same cycle shall be shifted into the top and bottom row shift registers. The first bit shifted in is column 0.
REQ-018 The FSM states shall be IDLE, SHIFT and COMMIT.
REQ-019 IDLE -> SHIFT on the first clk_shft rising edge. SHIFT -> COMMIT on a LAT rising edge. COMMIT -> IDLE after exactly one cycle.
REQ-020 The pixel counter shall be 7 bits wide, clear on entry to IDLE, increment per shift edge, and saturate at COLS+1.
REQ-021 In COMMIT with count==COLS, both shift registers shall be written to row memory at index {A..D} and {A..D}+ROWS_HALF, and row_done shall pulse.
REQ-022 In COMMIT with count!=COLS, memory shall be unchanged and col_err shall pulse. A LAT edge in IDLE (count 0) counts as an error.
REQ-023 A shift edge and a LAT edge on the same cycle: the shift is taken first, then the state moves to COMMIT.
REQ-024 Shift edges arriving during COMMIT are dropped; the panel driver guarantees a gap.
REQ-025 rd_rgb shall be registered with 1-cycle latency from rd_row/rd_col. A read of the row being committed returns the old data.
REQ-026 Out-of-range rd_row/rd_col shall return 3'b000.
REQ-027 frame_done shall be evaluated only on successful commits. Erroneous rows shall not update the previous-row tracker.

Reset
REQ-028 While rst=1 at a clk edge: FSM to IDLE; counter, synchronizers, previous-row tracker (set to 0) and all pulse outputs cleared; lit=0, rd_rgb=0.
REQ-029 Row memory contents are not cleared by reset. A reset mid-SHIFT discards the partial row.

Configuration
REQ-030 With HUB75_RX_ERRCNT_EN defined, an extra output err_cnt [7:0] shall count col_err pulses, saturate at 255, and clear on rst. Without the macro, the port and counter shall be absent and behaviour is otherwise identical.

Verification
REQ-031 Reset, then 64 shifts of alternating R0=1/0, LAT with A..D=3 -> row_done pulses once; rd_row=3, rd_col=0 gives rd_rgb=3'b100 after 1 cycle; rd_col=1 gives 3'b000.
REQ-032 63 shifts then LAT -> col_err pulses once, row_done=0, memory unchanged; with the macro defined, err_cnt=1.
REQ-033 Rows 0..15 committed in order, then row 0 -> frame_done pulses exactly once, on the second row-0 commit.
REQ-034 The 64th shift edge coincident with the LAT edge -> commit succeeds with count 64.
REQ-035 rst asserted after 30 shifts, then a 64-shift burst with row 5 and B1=1 -> rd_row=21 reads 3'b001 at every column.
REQ-036 300 short bursts with the macro defined -> err_cnt saturates at 255.
